// File: rtl/uart_rx_sram_writer.sv
// uart_rx_sram_writer
//   Takes words from the UART receive path, drops errored ones and queues
//   clean bytes in a small FIFO. A write FSM drains the FIFO into an external
//   SRAM over a request/ack port, placing bytes at consecutive wrapping
//   addresses.
//
//   Optional feature: define PARITY_CHECK_EN to also drop words whose
//   received parity bit (rx_data[8]) disagrees with the parity of
//   rx_data[7:0] (even when parity_sel=0, odd when parity_sel=1).
//
// Ports
//   SysClk       system clock, rising edge
//   rst          asynchronous active-high reset
//   rx_data      [7:0] data byte, [8] received parity bit
//   rx_valid     one-cycle strobe qualifying rx_data and the error flags
//   rx_oe/be/fe  overrun / break / framing error for the strobed word
//   parity_sel   0 = even, 1 = odd (only with PARITY_CHECK_EN)
//   wr_enable    allows the FSM to start new SRAM writes
//   addr_clr     one-cycle request to return the write address to 0
//   sram_addr    write address, stable while sram_we is high
//   sram_wdata   write data, stable while sram_we is high
//   sram_we      write request, held until ack or timeout
//   sram_ack     SRAM accepted the write this cycle
//   fifo_full    FIFO full
//   fifo_empty   FIFO empty
//   busy         FSM not idle
//   drop_count   saturating count of discarded words
//   err_timeout  sticky ack-timeout flag, cleared only by rst
module uart_rx_sram_writer #(
  parameter int ADDR_W      = 10,
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              SysClk,
  input  logic              rst,
  input  logic [8:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_oe,
  input  logic              rx_be,
  input  logic              rx_fe,
  input  logic              parity_sel,
  input  logic              wr_enable,
  input  logic              addr_clr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  output logic              sram_we,
  input  logic              sram_ack,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              busy,
  output logic [7:0]        drop_count,
  output logic              err_timeout
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t             state_q, state_d;
  logic [TO_W-1:0]    tcnt_q;
  logic               clr_pend_q;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               parity_err_p0;
  logic               word_err_p0;
  logic               push_p0;
  logic               drop_p0;
  logic               pop_p1;
  logic               timeout_hit;
  logic               clr_now;

  // ---- stage p0: qualify the incoming word ----
`ifdef PARITY_CHECK_EN
  always_comb begin
    parity_err_p0 = 1'b0;
    if (parity_sel) parity_err_p0 = (rx_data[8] != ~^rx_data[7:0]);
    else            parity_err_p0 = (rx_data[8] != ^rx_data[7:0]);
  end
`else
  logic unused_parity;
  assign unused_parity = rx_data[8] ^ parity_sel;
  assign parity_err_p0 = 1'b0;
`endif

  assign word_err_p0 = rx_oe | rx_be | rx_fe | parity_err_p0;
  // A full FIFO still takes the word if the FSM pops in the same cycle.
  assign push_p0     = rx_valid & ~word_err_p0 & (~fifo_full | pop_p1);
  assign drop_p0     = rx_valid & ~push_p0;

  // ---- stage p1: FIFO storage and FSM pop ----
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign pop_p1     = (state_q == S_IDLE) & wr_enable & ~fifo_empty;

  always_ff @(posedge SysClk) begin
    if (push_p0) mem[wr_ptr_q] <= rx_data[7:0];
  end

  always_ff @(posedge SysClk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_p0) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_p1)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_p0, pop_p1})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---- stage p2: SRAM write FSM ----
  // Timeout fires on the last REQ cycle only when ack is absent; a late ack
  // on that same cycle still completes the write.
  assign timeout_hit = (state_q == S_REQ) & ~sram_ack & (tcnt_q == TO_LAST);
  assign clr_now     = clr_pend_q | addr_clr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pop_p1) state_d = S_REQ;
      S_REQ: begin
        if (sram_ack)         state_d = S_DONE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SysClk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      clr_pend_q  <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      drop_count  <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= (state_q == S_REQ) ? tcnt_q + 1'b1 : '0;

      if (pop_p1)  sram_wdata <= mem[rd_ptr_q];
      if (drop_p0) drop_count <= sat_inc8(drop_count);
      if (timeout_hit) err_timeout <= 1'b1;

      // Address updates only outside an active request so it stays stable
      // while sram_we is high; a clear seen mid-request waits for the exit.
      if (state_q == S_DONE) begin
        sram_addr  <= clr_now ? '0 : sram_addr + 1'b1;
        clr_pend_q <= 1'b0;
      end else if (timeout_hit) begin
        if (clr_now) sram_addr <= '0;
        clr_pend_q <= 1'b0;
      end else if (state_q == S_REQ) begin
        if (addr_clr) clr_pend_q <= 1'b1;
      end else if (addr_clr) begin
        sram_addr <= '0;
      end
    end
  end

  assign sram_we = (state_q == S_REQ);
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sram_writer.sv
// Directed testbench for uart_rx_sram_writer (ADDR_W=10, FIFO_DEPTH=8,
// ACK_TIMEOUT=15). Inputs change on the falling edge; outputs are checked on
// the falling edge, half a cycle after the rising edge that updates them.
module tb_uart_rx_sram_writer;

  logic       SysClk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_oe = 1'b0, rx_be = 1'b0, rx_fe = 1'b0;
  logic       parity_sel = 1'b0;
  logic       wr_enable = 1'b0;
  logic       addr_clr = 1'b0;
  logic [9:0] sram_addr;
  logic [7:0] sram_wdata;
  logic       sram_we;
  logic       sram_ack = 1'b0;
  logic       fifo_full, fifo_empty, busy;
  logic [7:0] drop_count;
  logic       err_timeout;

  int total = 0;
  int bad   = 0;

  uart_rx_sram_writer #(.ADDR_W(10), .FIFO_DEPTH(8), .ACK_TIMEOUT(15)) dut (
    .SysClk(SysClk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_oe(rx_oe), .rx_be(rx_be), .rx_fe(rx_fe), .parity_sel(parity_sel),
    .wr_enable(wr_enable), .addr_clr(addr_clr), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_ack(sram_ack),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .busy(busy),
    .drop_count(drop_count), .err_timeout(err_timeout)
  );

  always #5 SysClk = ~SysClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0; rx_oe = 1'b0; rx_be = 1'b0; rx_fe = 1'b0;
    wr_enable = 1'b0; addr_clr = 1'b0; sram_ack = 1'b0; parity_sel = 1'b0;
    @(negedge SysClk);
    @(negedge SysClk);
    rst = 1'b0;
  endtask

  // One-cycle strobe; returns on the following falling edge.
  task automatic strobe(input logic [8:0] d, input logic oe, input logic be, input logic fe);
    rx_data = d; rx_oe = oe; rx_be = be; rx_fe = fe; rx_valid = 1'b1;
    @(negedge SysClk);
    rx_valid = 1'b0; rx_oe = 1'b0; rx_be = 1'b0; rx_fe = 1'b0;
  endtask

  task automatic wait_we();
    for (int n = 0; n < 30 && !sram_we; n++) @(negedge SysClk);
    chk("we_seen", {31'd0, sram_we}, 32'd1);
  endtask

  // Ack for one cycle; returns once the FSM has passed DONE and is idle.
  task automatic ack_pulse();
    sram_ack = 1'b1;
    @(negedge SysClk);
    sram_ack = 1'b0;
    @(negedge SysClk);
  endtask

  task automatic write_one(input logic [7:0] d);
    strobe({1'b0, d}, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 30 && !sram_we; n++) @(negedge SysClk);
    ack_pulse();
  endtask

  initial begin
    int n;

    // Reset values
    @(negedge SysClk);
    chk("rst_addr",  {22'd0, sram_addr}, 32'd0);
    chk("rst_wdata", {24'd0, sram_wdata}, 32'd0);
    chk("rst_we",    {31'd0, sram_we}, 32'd0);
    chk("rst_full",  {31'd0, fifo_full}, 32'd0);
    chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_drop",  {24'd0, drop_count}, 32'd0);
    chk("rst_err",   {31'd0, err_timeout}, 32'd0);
    do_reset();

    // Single byte: request two cycles after the strobe, ack one cycle later
    wr_enable = 1'b1;
    strobe(9'h0A5, 1'b0, 1'b0, 1'b0);
    chk("one_empty_p1", {31'd0, fifo_empty}, 32'd0);
    chk("one_we_p1",    {31'd0, sram_we}, 32'd0);
    @(negedge SysClk);
    chk("one_we_p2",    {31'd0, sram_we}, 32'd1);
    chk("one_addr",     {22'd0, sram_addr}, 32'd0);
    chk("one_data",     {24'd0, sram_wdata}, 32'hA5);
    @(negedge SysClk);
    chk("one_we_hold",  {31'd0, sram_we}, 32'd1);
    ack_pulse();
    chk("one_addr_next", {22'd0, sram_addr}, 32'd1);
    chk("one_busy",      {31'd0, busy}, 32'd0);

    // Ack outside a request has no effect
    sram_ack = 1'b1;
    @(negedge SysClk);
    sram_ack = 1'b0;
    @(negedge SysClk);
    chk("stray_ack_addr", {22'd0, sram_addr}, 32'd1);
    chk("stray_ack_busy", {31'd0, busy}, 32'd0);

    // Burst with writes held off: fill, overflow, then drain in order
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rx_data = {1'b0, 8'(16 + i)};
      rx_valid = 1'b1;
      @(negedge SysClk);
    end
    chk("burst_full", {31'd0, fifo_full}, 32'd1);
    rx_data = 9'h099;
    @(negedge SysClk);
    rx_valid = 1'b0;
    chk("burst_drop", {24'd0, drop_count}, 32'd1);
    wr_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_we();
      chk("burst_addr", {22'd0, sram_addr}, 32'(i));
      chk("burst_data", {24'd0, sram_wdata}, 32'(16 + i));
      ack_pulse();
    end
    chk("burst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("burst_addr_end", {22'd0, sram_addr}, 32'd8);

    // Full FIFO with a pop in the same cycle accepts the push
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rx_data = {1'b0, 8'(16 + i)};
      rx_valid = 1'b1;
      @(negedge SysClk);
    end
    rx_data = 9'h077;
    wr_enable = 1'b1;
    @(negedge SysClk);
    rx_valid = 1'b0;
    chk("fullpop_drop", {24'd0, drop_count}, 32'd0);
    chk("fullpop_full", {31'd0, fifo_full}, 32'd1);
    chk("fullpop_data", {24'd0, sram_wdata}, 32'h10);

    // Errored words are dropped, nothing pushed
    do_reset();
    wr_enable = 1'b1;
    strobe(9'h011, 1'b0, 1'b0, 1'b1);
    strobe(9'h022, 1'b1, 1'b0, 1'b0);
    strobe(9'h033, 1'b0, 1'b1, 1'b0);
    @(negedge SysClk);
    chk("err_drop",  {24'd0, drop_count}, 32'd3);
    chk("err_empty", {31'd0, fifo_empty}, 32'd1);
    chk("err_we",    {31'd0, sram_we}, 32'd0);

    // drop_count saturates
    for (int i = 0; i < 260; i++) strobe(9'h000, 1'b0, 1'b0, 1'b1);
    chk("drop_sat", {24'd0, drop_count}, 32'hFF);

    // Ack timeout: 15 request cycles, sticky error, address kept
    do_reset();
    wr_enable = 1'b1;
    strobe(9'h05A, 1'b0, 1'b0, 1'b0);
    wait_we();
    n = 0;
    for (int k = 0; k < 40 && sram_we; k++) begin
      n++;
      @(negedge SysClk);
    end
    chk("to_len",  32'(n), 32'd15);
    chk("to_err",  {31'd0, err_timeout}, 32'd1);
    chk("to_addr", {22'd0, sram_addr}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    strobe(9'h06B, 1'b0, 1'b0, 1'b0);
    wait_we();
    chk("to_next_addr", {22'd0, sram_addr}, 32'd0);
    chk("to_next_data", {24'd0, sram_wdata}, 32'h6B);
    ack_pulse();
    chk("to_next_done", {22'd0, sram_addr}, 32'd1);
    chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);

    // Asynchronous reset mid-request drops sram_we at once
    strobe(9'h0C4, 1'b0, 1'b0, 1'b0);
    wait_we();
    #2 rst = 1'b1;
    #1;
    chk("arst_we",   {31'd0, sram_we}, 32'd0);
    chk("arst_addr", {22'd0, sram_addr}, 32'd0);
    chk("arst_err",  {31'd0, err_timeout}, 32'd0);
    do_reset();

    // Address wrap at 1023 and addr_clr during a request
    wr_enable = 1'b1;
    for (int i = 0; i < 1023; i++) write_one(8'(i));
    chk("wrap_pre", {22'd0, sram_addr}, 32'd1023);
    strobe(9'h0EE, 1'b0, 1'b0, 1'b0);
    wait_we();
    chk("wrap_addr", {22'd0, sram_addr}, 32'd1023);
    chk("wrap_data", {24'd0, sram_wdata}, 32'hEE);
    ack_pulse();
    chk("wrap_post", {22'd0, sram_addr}, 32'd0);
    write_one(8'h01);
    write_one(8'h02);
    strobe(9'h0AB, 1'b0, 1'b0, 1'b0);
    wait_we();
    chk("clr_req_addr", {22'd0, sram_addr}, 32'd2);
    addr_clr = 1'b1;
    @(negedge SysClk);
    addr_clr = 1'b0;
    chk("clr_hold_addr", {22'd0, sram_addr}, 32'd2);
    ack_pulse();
    chk("clr_after_done", {22'd0, sram_addr}, 32'd0);

    // Parity handling
    do_reset();
    wr_enable = 1'b1;
`ifdef PARITY_CHECK_EN
    // Even: expected bit = ^8'h01 = 1, so 9'h001 is bad and 9'h101 is good.
    parity_sel = 1'b0;
    strobe(9'h001, 1'b0, 1'b0, 1'b0);
    @(negedge SysClk);
    chk("par_even_bad", {24'd0, drop_count}, 32'd1);
    chk("par_even_empty", {31'd0, fifo_empty}, 32'd1);
    strobe(9'h101, 1'b0, 1'b0, 1'b0);
    wait_we();
    chk("par_even_good", {24'd0, sram_wdata}, 32'h01);
    ack_pulse();
    // Odd: expected bit = ~^8'h01 = 0, so 9'h101 is bad.
    parity_sel = 1'b1;
    strobe(9'h101, 1'b0, 1'b0, 1'b0);
    @(negedge SysClk);
    chk("par_odd_bad", {24'd0, drop_count}, 32'd2);
`else
    // Without the check the parity bit is ignored.
    parity_sel = 1'b1;
    strobe(9'h1C3, 1'b0, 1'b0, 1'b0);
    wait_we();
    chk("nopar_data", {24'd0, sram_wdata}, 32'hC3);
    ack_pulse();
    strobe(9'h001, 1'b0, 1'b0, 1'b0);
    wait_we();
    chk("nopar_data2", {24'd0, sram_wdata}, 32'h01);
    ack_pulse();
    chk("nopar_drop", {24'd0, drop_count}, 32'd0);
    chk("nopar_addr", {22'd0, sram_addr}, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
